// File: rtl/ps_packet_sequencer.sv
// ps_packet_sequencer: arbitrates trigger/heartbeat requests and streams the 10-byte ROM packet to the encoder.
// Optional PS_SEQ_STATS_EN adds saturating trigger sent/drop counters.
module ps_packet_sequencer #(
    parameter int HEARTBEAT_PERIOD = 1000000,
    parameter int GAP_CYCLES       = 4,
    parameter int PKT_LEN          = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trigger_req,
    input  logic [7:0] rom_data,
    output logic [3:0] rom_address,
    output logic       rom_is_trigger,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy
`ifdef PS_SEQ_STATS_EN
    ,
    output logic [15:0] trig_sent_cnt,
    output logic [15:0] trig_drop_cnt
`endif
);
    localparam int HW = $clog2(HEARTBEAT_PERIOD);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    state_t state;
    logic [HW-1:0] hb_cnt;
    logic [GW-1:0] gap_cnt;
    logic trig_pend, hb_pend;
    logic wrap, accept, last, arb, take_trig, take_hb;
    assign wrap      = hb_cnt == HW'(HEARTBEAT_PERIOD - 1);
    assign accept    = tx_valid & tx_ready;
    assign last      = rom_address == 4'(PKT_LEN - 1);
    assign arb       = state == IDLE || (state == GAP && gap_cnt == GW'(GAP_CYCLES - 1));
    assign take_trig = arb & trig_pend;
    assign take_hb   = arb & ~trig_pend & hb_pend;
    assign tx_data   = rom_data;
    // K flag from the registered address keeps tx_ready off every output path
    assign tx_k      = tx_valid & (rom_address == 4'd0 | last);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            hb_cnt         <= '0;
            gap_cnt        <= '0;
            trig_pend      <= 1'b0;
            hb_pend        <= 1'b0;
            rom_address    <= '0;
            rom_is_trigger <= 1'b0;
            tx_valid       <= 1'b0;
            busy           <= 1'b0;
        end else begin
            hb_cnt    <= wrap ? '0 : hb_cnt + 1'b1;
            trig_pend <= take_trig ? 1'b0 : trig_pend | trigger_req;
            hb_pend   <= wrap | (hb_pend & ~take_hb);
            if (take_trig || take_hb) begin
                state          <= SEND;
                tx_valid       <= 1'b1;
                busy           <= 1'b1;
                rom_is_trigger <= take_trig;
                rom_address    <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
                if (arb) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == SEND && accept) begin
                if (last) begin
                    state       <= GAP;
                    gap_cnt     <= '0;
                    tx_valid    <= 1'b0;
                    rom_address <= '0;
                end else begin
                    rom_address <= rom_address + 1'b1;
                end
            end
        end
    end
`ifdef PS_SEQ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_sent_cnt <= '0;
            trig_drop_cnt <= '0;
        end else begin
            if (state == SEND && accept && last && rom_is_trigger && trig_sent_cnt != 16'hFFFF)
                trig_sent_cnt <= trig_sent_cnt + 1'b1;
            if (trigger_req && trig_pend && trig_drop_cnt != 16'hFFFF)
                trig_drop_cnt <= trig_drop_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ps_packet_sequencer.sv
// tb_ps_packet_sequencer: directed scenarios with a stub packet ROM and hand-computed byte streams.
module tb_ps_packet_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       trigger_req = 1'b0;
    logic [7:0] rom_data;
    logic [3:0] rom_address;
    logic       rom_is_trigger;
    logic [7:0] tx_data;
    logic       tx_k;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
`ifdef PS_SEQ_STATS_EN
    logic [15:0] trig_sent_cnt, trig_drop_cnt;
`endif
    int vectors = 0;
    int errors = 0;

    ps_packet_sequencer #(.HEARTBEAT_PERIOD(100), .GAP_CYCLES(2), .PKT_LEN(10)) dut (
        .clk(clk), .rst(rst), .trigger_req(trigger_req), .rom_data(rom_data),
        .rom_address(rom_address), .rom_is_trigger(rom_is_trigger), .tx_data(tx_data),
        .tx_k(tx_k), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
`ifdef PS_SEQ_STATS_EN
        , .trig_sent_cnt(trig_sent_cnt), .trig_drop_cnt(trig_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stub packet ROM: SOP, type byte at address 2, EOP at address 9
    always_comb
        rom_data = rom_address == 4'd0 ? 8'h3C :
                   rom_address == 4'd9 ? 8'hBC :
                   rom_address == 4'd2 ? (rom_is_trigger ? 8'h70 : 8'h40) : 8'h00;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        trigger_req = 1'b0;
        tx_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic pulse;
        trigger_req = 1'b1;
        tick;
        trigger_req = 1'b0;
    endtask

    task automatic recv_packet(input logic trig, input bit toggle, input logic [39:0] pulses, output int cycles);
        logic [7:0] exp_b [10];
        int idx, w;
        exp_b = '{8'h3C, 8'h00, trig ? 8'h70 : 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBC};
        w = 0;
        while (!tx_valid && w < 20) begin
            tick;
            w++;
        end
        vectors++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL sop_timeout: tx_valid=%b required 1 within 20 cycles", tx_valid);
        end
        idx = 0;
        cycles = 0;
        if (toggle) tx_ready = 1'b0;
        while (idx < 10 && cycles < 40) begin
            trigger_req = pulses[cycles];
            vectors++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[idx] || tx_k !== logic'(idx == 0 || idx == 9) || rom_is_trigger !== trig) begin
                errors++;
                $display("FAIL byte%0d: valid=%b data=%h k=%b trig=%b required valid=1 data=%h k=%b trig=%b",
                         idx, tx_valid, tx_data, tx_k, rom_is_trigger, exp_b[idx], idx == 0 || idx == 9, trig);
            end
            if (tx_ready) idx++;
            tick;
            cycles++;
            if (toggle) tx_ready = ~tx_ready;
        end
        trigger_req = 1'b0;
        tx_ready = 1'b1;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_eop_valid: tx_valid=%b required 0", tx_valid);
        end
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if (rom_address !== 4'd0 || rom_is_trigger !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || tx_k !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: addr=%0d trig=%b valid=%b busy=%b k=%b required 0 0 0 0 0",
                     rom_address, rom_is_trigger, tx_valid, busy, tx_k);
        end
    endtask

    task automatic test_trigger;
        int c;
        do_reset;
        repeat (8) tick;
        pulse;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL trig_latency1: tx_valid=%b required 0", tx_valid);
        end
        tick;
        vectors++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL trig_latency2: valid=%b busy=%b required 1 1", tx_valid, busy);
        end
        recv_packet(1'b1, 1'b0, 40'h0, c);
        vectors++;
        if (c !== 10) begin
            errors++;
            $display("FAIL trig_span: %0d cycles required 10", c);
        end
        vectors++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL gap1_busy: busy=%b required 1", busy);
        end
        tick;
        vectors++;
        if (busy !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap2: busy=%b valid=%b required 1 0", busy, tx_valid);
        end
        tick;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_heartbeat;
        int c;
        do_reset;
        repeat (100) tick;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL hb_early: tx_valid=%b required 0 at wrap", tx_valid);
        end
        tick;
        vectors++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL hb_first_sop: tx_valid=%b required 1", tx_valid);
        end
        recv_packet(1'b0, 1'b0, 40'h0, c);
        repeat (89) tick;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL hb2_early: tx_valid=%b required 0", tx_valid);
        end
        tick;
        vectors++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL hb_second_sop: tx_valid=%b required 1", tx_valid);
        end
        recv_packet(1'b0, 1'b0, 40'h0, c);
    endtask

    task automatic test_ready_toggle;
        int c;
        do_reset;
        repeat (5) tick;
        pulse;
        recv_packet(1'b1, 1'b1, 40'h0, c);
        vectors++;
        if (c !== 20) begin
            errors++;
            $display("FAIL toggle_span: %0d cycles required 20", c);
        end
    endtask

    task automatic test_simultaneous;
        int c;
        do_reset;
        repeat (99) tick;
        pulse;
        recv_packet(1'b1, 1'b0, 40'h0, c);
        tick;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_gap2: tx_valid=%b required 0", tx_valid);
        end
        tick;
        vectors++;
        if (tx_valid !== 1'b1 || rom_is_trigger !== 1'b0) begin
            errors++;
            $display("FAIL sim_hb_start: valid=%b trig=%b required 1 0", tx_valid, rom_is_trigger);
        end
        recv_packet(1'b0, 1'b0, 40'h0, c);
    endtask

    task automatic test_three_triggers;
        int c, extra;
        do_reset;
        repeat (3) tick;
        pulse;
        recv_packet(1'b1, 1'b0, 40'h2A, c);
        tick;
        vectors++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL three_gap: tx_valid=%b required 0", tx_valid);
        end
        recv_packet(1'b1, 1'b0, 40'h0, c);
        extra = 0;
        repeat (30) begin
            if (tx_valid) extra++;
            tick;
        end
        vectors++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL three_extra: %0d valid cycles after second packet required 0", extra);
        end
`ifdef PS_SEQ_STATS_EN
        vectors++;
        if (trig_drop_cnt !== 16'd2 || trig_sent_cnt !== 16'd2) begin
            errors++;
            $display("FAIL stats: drop=%0d sent=%0d required 2 2", trig_drop_cnt, trig_sent_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int c;
        do_reset;
        repeat (4) tick;
        pulse;
        tick;
        repeat (5) tick;
        vectors++;
        if (rom_address !== 4'd5 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_addr: addr=%0d valid=%b required 5 1", rom_address, tx_valid);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (tx_valid !== 1'b0 || rom_address !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b addr=%0d busy=%b required 0 0 0", tx_valid, rom_address, busy);
        end
        tick;
        rst = 1'b0;
        tick;
        pulse;
        recv_packet(1'b1, 1'b0, 40'h0, c);
    endtask

    initial begin
        test_reset;
        test_trigger;
        test_heartbeat;
        test_ready_toggle;
        test_simultaneous;
        test_three_triggers;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
